// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: redirect FSM encoding, reset vector
// default, instruction size and target alignment helper.
package pipeline_pkg;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES          = 32'd4;

   // Redirect FSM encoding
   typedef logic [0:0] state_t;
   localparam state_t RUN     = 1'b0;
   localparam state_t PENDING = 1'b1;

   // Force a fetch target onto a word boundary
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_redirect_ctrl_counter.sv
// Free-running wrap counter of applied redirects, synchronous clear.
module redirect_counter #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 en,
   output logic [CNT_WIDTH-1:0] count
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Clear wins; otherwise count up and wrap naturally
   always_ff @(posedge clk) begin
      if (clr)
         count <= '0;
      else if (en)
         count <= count + ONE;
   end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program counter owner: applies EX-stage redirects to fetch, flushes
// wrong-path IF/ID and ID/EX contents, and defers a redirect while the
// instruction memory is still busy with the current fetch.
module pc_redirect_ctrl
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 BRANCH_TAKEN,
   input  logic [31:0]          BRANCH_TARGET,
   input  logic                 STALL,
   input  logic                 IMEM_BUSYWAIT,
   output logic [31:0]          PC,
   output logic [31:0]          PC_PLUS_4,
   output logic                 IMEM_READ,
   output logic                 FLUSH_IF_ID,
   output logic                 FLUSH_ID_EX,
   output logic                 TARGET_MISALIGNED,
   output logic [CNT_WIDTH-1:0] REDIRECT_COUNT
);

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_q;
   logic        misal_q;
   logic [31:0] tgt_aligned;
   logic        apply_redirect;
   logic        flush;

   assign tgt_aligned = align_word(BRANCH_TARGET);
   assign PC          = pc_q;
   assign PC_PLUS_4   = pc_q + INSTR_BYTES;

   // Fetch request, flush and redirect-apply decode for the current cycle
   always_comb begin
      IMEM_READ      = 1'b0;
      flush          = 1'b0;
      apply_redirect = 1'b0;
      if (!RESET) begin
         IMEM_READ = 1'b1;
         if (state_q == PENDING) begin
            // Whatever returns from the in-flight fetch is wrong-path
            flush          = 1'b1;
            apply_redirect = !IMEM_BUSYWAIT;
         end else begin
            flush          = BRANCH_TAKEN;
            apply_redirect = BRANCH_TAKEN && !IMEM_BUSYWAIT;
         end
      end
   end

   assign FLUSH_IF_ID       = flush;
   assign FLUSH_ID_EX       = flush;
   assign TARGET_MISALIGNED = misal_q;

   // PC, pending target and FSM; a taken branch beats a stall since it is older
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pc_q    <= RESET_VECTOR;
         pend_q  <= '0;
         state_q <= RUN;
         misal_q <= 1'b0;
      end else begin
         misal_q <= BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
         if (state_q == RUN) begin
            if (BRANCH_TAKEN) begin
               if (IMEM_BUSYWAIT) begin
                  pend_q  <= tgt_aligned;
                  state_q <= PENDING;
               end else begin
                  pc_q <= tgt_aligned;
               end
            end else if (!IMEM_BUSYWAIT && !STALL) begin
               pc_q <= pc_q + INSTR_BYTES;
            end
         end else begin
            // A fresh branch here replaces the older pending target
            if (BRANCH_TAKEN)
               pend_q <= tgt_aligned;
            if (!IMEM_BUSYWAIT) begin
               pc_q    <= BRANCH_TAKEN ? tgt_aligned : pend_q;
               state_q <= RUN;
            end
         end
      end
   end

   redirect_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_redirect_counter (
      .clk   (CLK),
      .clr   (RESET),
      .en    (apply_redirect),
      .count (REDIRECT_COUNT)
   );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl (counter narrowed to 4 bits).
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        bt;
   logic [31:0] tgt;
   logic        stall;
   logic        busy;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        imem_read;
   logic        fl_ifid;
   logic        fl_idex;
   logic        misal;
   logic [3:0]  cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(
      .RESET_VECTOR (32'h0000_0000),
      .CNT_WIDTH    (4)
   ) dut (
      .CLK               (clk),
      .RESET             (rst),
      .BRANCH_TAKEN      (bt),
      .BRANCH_TARGET     (tgt),
      .STALL             (stall),
      .IMEM_BUSYWAIT     (busy),
      .PC                (pc),
      .PC_PLUS_4         (pc4),
      .IMEM_READ         (imem_read),
      .FLUSH_IF_ID       (fl_ifid),
      .FLUSH_ID_EX       (fl_idex),
      .TARGET_MISALIGNED (misal),
      .REDIRECT_COUNT    (cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive inputs, then let combinational outputs settle
   task automatic drive(input logic r, input logic b, input logic [31:0] t,
                        input logic s, input logic bw);
      rst   = r;
      bt    = b;
      tgt   = t;
      stall = s;
      busy  = bw;
      #1;
   endtask

   task automatic chk_flush(input string tag, input logic exp);
      chk({tag, "_ifid"}, {31'd0, fl_ifid}, {31'd0, exp});
      chk({tag, "_idex"}, {31'd0, fl_idex}, {31'd0, exp});
   endtask

   initial begin
      // Reset for two edges
      drive(1, 0, 0, 0, 0);
      chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
      chk_flush("rst_flush", 1'b0);
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_cnt", {28'd0, cnt}, 32'd0);
      chk("rst_misal", {31'd0, misal}, 32'd0);
      tick();
      chk("rst_pc2", pc, 32'h0);

      // Run: 0 -> 4 -> 8 -> 12 -> 16
      drive(0, 0, 0, 0, 0);
      chk("run_imem_read", {31'd0, imem_read}, 32'd1);
      chk_flush("run_flush", 1'b0);
      chk("run_pc0", pc, 32'h0);
      tick();
      chk("run_pc4", pc, 32'h4);
      tick();
      chk("run_pc8", pc, 32'h8);
      tick();
      chk("run_pc12", pc, 32'hC);
      tick();
      chk("run_pc16", pc, 32'h10);

      // Stall holds PC
      drive(0, 0, 0, 1, 0);
      chk_flush("stall_flush", 1'b0);
      tick();
      chk("stall_pc", pc, 32'h10);

      // Branch overrides stall
      drive(0, 1, 32'h200, 1, 0);
      chk_flush("brstall_flush", 1'b1);
      tick();
      chk("brstall_pc", pc, 32'h200);
      chk("brstall_cnt", {28'd0, cnt}, 32'd1);

      // Redirect under busy: accept + 3 busy cycles, then busy drops
      drive(0, 1, 32'h80, 0, 1);
      chk_flush("busy_c1_flush", 1'b1);
      tick();
      chk("busy_c1_pc", pc, 32'h200);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, (i == 1), 1);
         chk_flush("busy_hold_flush", 1'b1);
         tick();
         chk("busy_hold_pc", pc, 32'h200);
         chk("busy_hold_cnt", {28'd0, cnt}, 32'd1);
      end
      drive(0, 0, 0, 1, 0);
      chk_flush("busy_drop_flush", 1'b1);
      tick();
      chk("busy_apply_pc", pc, 32'h80);
      chk("busy_apply_cnt", {28'd0, cnt}, 32'd2);
      chk("busy_misal", {31'd0, misal}, 32'd0);
      drive(0, 0, 0, 0, 0);
      chk_flush("busy_after_flush", 1'b0);

      // Misaligned target applied directly
      drive(0, 1, 32'h103, 0, 0);
      tick();
      chk("misal_pc", pc, 32'h100);
      chk("misal_pulse", {31'd0, misal}, 32'd1);
      chk("misal_cnt", {28'd0, cnt}, 32'd3);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("misal_clear", {31'd0, misal}, 32'd0);
      chk("misal_adv_pc", pc, 32'h104);

      // Reset mid-PENDING discards target
      drive(0, 1, 32'h40, 0, 1);
      tick();
      chk("rstpend_hold_pc", pc, 32'h104);
      drive(1, 0, 0, 0, 1);
      chk("rstpend_imem_read", {31'd0, imem_read}, 32'd0);
      chk_flush("rstpend_flush", 1'b0);
      tick();
      chk("rstpend_pc", pc, 32'h0);
      chk("rstpend_cnt", {28'd0, cnt}, 32'd0);
      drive(0, 0, 0, 0, 0);
      chk_flush("rstpend_run_flush", 1'b0);
      tick();
      chk("rstpend_no_jump", pc, 32'h4);
      chk("rstpend_cnt2", {28'd0, cnt}, 32'd0);

      // Counter wrap: 17 redirects on a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         drive(0, 1, 32'h1000 + 32'(i) * 32'h10, 0, 0);
         tick();
      end
      chk("wrap_pc", pc, 32'h1100);
      chk("wrap_cnt", {28'd0, cnt}, 32'd1);

      // PC wrap at top of address space
      drive(0, 1, 32'hFFFF_FFFC, 0, 0);
      tick();
      chk("pcwrap_top", pc, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 0);
      chk("pcwrap_plus4", pc4, 32'h0);
      tick();
      chk("pcwrap_pc", pc, 32'h0);
      chk("pcwrap_cnt", {28'd0, cnt}, 32'd2);

      // Misaligned latch into PENDING; no second pulse on apply
      drive(0, 1, 32'h202, 0, 1);
      tick();
      chk("pmisal_pulse", {31'd0, misal}, 32'd1);
      chk("pmisal_hold_pc", pc, 32'h0);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("pmisal_apply_pc", pc, 32'h200);
      chk("pmisal_no_repulse", {31'd0, misal}, 32'd0);
      chk("pmisal_cnt", {28'd0, cnt}, 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
